sobel_window_gen: RTL and testbench
===================================

Name: sobel_window_gen

Overview:
- Producer end of the 3x3-window handshake that the sobel kernels consume.
- Accepts a raster-order pixel stream, one pixel per beat, and buffers two previous lines.
- Presents each complete 3x3 neighbourhood as a packed 9-pixel word to a downstream kernel.
- Holds each window until the kernel is not busy. Sits between the pixel source and sobel_gx/sobel_gy.

Parameters:
- p_data_bits, 8, bits per pixel.
- p_line_width, 640, pixels per line W; must be >= 3.
- p_frame_height, 480, lines per frame H; must be >= 3.

Ports:
- i_clk  input  1  clock, all logic on rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  upstream pixel valid.
- data_in  input  p_data_bits  upstream pixel.
- ready_out  output  1  pixel accepted when valid_in && ready_out.
- busy_in  input  1  kernel busy; window transferred on a cycle with valid_out && !busy_in.
- valid_out  output  1  window valid to kernel.
- data_out  output  9*p_data_bits  packed window.
- last_out  output  1  marks the final window of a frame; qualified by valid_out.

Behaviour:
- Reset (asynchronous, active-high, i_rst): valid_out=0, last_out=0, data_out=0, col=0, row=0, state=ACCEPT. ready_out reads 1 once reset releases. Line-buffer RAM contents are not reset.
- ready_out = !valid_out (combinational, no busy_in path). At most one window is outstanding.
- Pixel accept (valid_in && ready_out):
  - new column = {lineA[col], lineB[col], data_in}, ordered top (oldest row) to bottom.
  - Window shift register shifts left by one column; the new column enters at col position 2.
  - lineA[col] <= lineB[col]; lineB[col] <= data_in.
  - col increments; at W-1 it wraps to 0 and row increments; at row H-1 with col W-1, row wraps to 0.
- Window emit: if the accepted pixel has col>=2 and row>=2, the next cycle presents the updated window.
  - valid_out=1; state=HOLD.
  - last_out=1 iff that pixel was (row H-1, col W-1).
  - Otherwise state stays ACCEPT.
  - Latency: pixel accept edge -> valid_out high one cycle later.
- Windows never span a line boundary because they are only emitted at col>=2. Exactly (W-2)*(H-2) windows are emitted per frame.
- HOLD:
  - data_out and last_out stay stable while valid_out=1.
  - When valid_out && !busy_in, the window is taken: valid_out and last_out go 0 next cycle, state=ACCEPT, and ready_out returns 1.
  - busy_in is ignored while valid_out=0.
- Packing, MSB first, pN_M = row N (0 = top/oldest), column M (0 = left/oldest):
  - [9P-1 -: P] = p0_0, then p1_0, p2_0
  - then p0_1, p1_1, p2_1
  - then p0_2, p1_2, p2_2 (LSBs)
  - This is column-major, matching the kernels' a<col><row> decode.
- Simultaneous events:
  - A pixel offered in the same cycle a window is taken is not accepted (ready_out=0 that cycle). It is accepted on the following cycle at the earliest.
  - valid_in low in ACCEPT: no state change.
- Frame boundary: counters wrap and the next frame starts without flush cycles. Stale line contents are overwritten before use, because rows 0-1 of each frame emit nothing.
- Reset mid-frame or mid-HOLD: a pending window is dropped, counters return to 0, and the next accepted pixel is treated as (row 0, col 0).
- Counters are sized $clog2(W) and $clog2(H). No arithmetic is performed on pixel data.

Test Plan:
- W=5, H=4, pixel = row*16+col, busy_in=0, valid_in always 1:
  - first valid_out occurs one cycle after pixel (2,2) is accepted.
  - data_out = {00,10,20,01,11,21,02,12,22}.
- Same stream: exactly 6 windows, last_out=1 only on the window ending at pixel (3,4), = {12,22,32,13,23,33,14,24,34}.
- busy_in=1 for 10 cycles while valid_out=1:
  - data_out is stable and ready_out=0 throughout.
  - on busy_in=0 the transfer completes in one cycle and ready_out=1 the next cycle.
- Three back-to-back frames with random valid_in gaps: 18 windows total, last_out on windows 6, 12 and 18, and contents equal the reference model.
- Assert i_rst asynchronously mid-HOLD in frame 1: valid_out drops immediately and the window is not delivered; a restarted frame yields first window {00,10,20,01,11,21,02,12,22}.
- Single-cycle take with valid_in held high: no pixel is accepted on the take cycle, and the pixel is accepted on the next cycle.

Source files
------------

// File: rtl/sobel_window_gen_if.sv
// Pixel-in / window-out handshake between the pixel source, the window
// generator and the sobel kernels.
interface sobel_window_gen_if #(
  parameter int p_data_bits = 8
);
  logic                     valid_in;
  logic [p_data_bits-1:0]   data_in;
  logic                     ready_out;
  logic                     busy_in;
  logic                     valid_out;
  logic [9*p_data_bits-1:0] data_out;
  logic                     last_out;

  modport master (
    output valid_in, data_in, busy_in,
    input  ready_out, valid_out, data_out, last_out
  );

  modport slave (
    input  valid_in, data_in, busy_in,
    output ready_out, valid_out, data_out, last_out
  );
endinterface

// File: rtl/sobel_window_gen.sv
// Two-line-buffer 3x3 window generator: raster pixels in, one column-major
// packed 3x3 window out per interior pixel, held until the kernel takes it.
module sobel_window_gen #(
  parameter int p_data_bits    = 8,
  parameter int p_line_width   = 640,
  parameter int p_frame_height = 480
) (
  input  logic             i_clk,
  input  logic             i_rst,
  sobel_window_gen_if.slave bus
);
  localparam int P  = p_data_bits;
  localparam int W  = p_line_width;
  localparam int H  = p_frame_height;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int RW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic {ACCEPT, HOLD} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [9*P-1:0]  win_q, win_d;
  logic            last_q, last_d;

  // lineA holds row r-2, lineB row r-1 at the column being written
  logic [P-1:0]    line_a_mem [W];
  logic [P-1:0]    line_b_mem [W];

  logic            ready, accept, take, emit, col_end, row_end;
  logic [3*P-1:0]  new_col;

  always_comb begin
    accept  = bus.valid_in && ready;
    take    = (state_q == HOLD) && !bus.busy_in;
    col_end = (col_q == CW'(W - 1));
    row_end = (row_q == RW'(H - 1));
    emit    = accept && (col_q >= CW'(2)) && (row_q >= RW'(2));
    new_col = {line_a_mem[col_q], line_b_mem[col_q], bus.data_in};

    col_d  = col_q;
    row_d  = row_q;
    win_d  = win_q;
    last_d = last_q;
    if (accept) begin
      win_d = {win_q[6*P-1:0], new_col};
      col_d = col_end ? '0 : col_q + CW'(1);
      if (col_end) row_d = row_end ? '0 : row_q + RW'(1);
    end
    if (emit)      last_d = col_end && row_end;
    else if (take) last_d = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ACCEPT;
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      last_q  <= last_d;
    end
  end

  // Line RAM carries no reset; rows 0-1 of every frame refill it before use
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_a_mem[col_q] <= line_b_mem[col_q];
      line_b_mem[col_q] <= bus.data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCEPT:  if (emit) state_d = HOLD;
      HOLD:    if (take) state_d = ACCEPT;
      default: state_d = ACCEPT;
    endcase
  end

  always_comb begin
    ready         = (state_q == ACCEPT);
    bus.ready_out = ready;
    bus.valid_out = (state_q == HOLD);
    bus.data_out  = win_q;
    bus.last_out  = last_q;
  end
endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on a 5x4 frame.
module tb_sobel_window_gen;
  localparam int W = 5;
  localparam int H = 4;
  localparam int P = 8;
  localparam logic [71:0] FIRST_WIN = 72'h00_10_20_01_11_21_02_12_22;
  localparam logic [71:0] LAST_WIN  = 72'h12_22_32_13_23_33_14_24_34;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  sobel_window_gen_if #(.p_data_bits(P)) bus ();

  sobel_window_gen #(
    .p_data_bits   (P),
    .p_line_width  (W),
    .p_frame_height(H)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  typedef struct {
    logic [71:0] data;
    logic        last;
    int          f;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0, n_err = 0, n_win = 0, n_last = 0;
  int   drv_f = 0, drv_r = 0, drv_c = 0;
  bit   pend = 0, took = 0, first_chk = 1, busy_rand = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int f, input int r, input int c);
    return 8'(r * 16 + c + f * 64);
  endfunction

  function automatic logic [71:0] win_at(input int f, input int r, input int c);
    logic [71:0] w = '0;
    for (int m = 0; m < 3; m++)
      for (int n = 0; n < 3; n++)
        w = {w[63:0], pix(f, r - 2 + n, c - 2 + m)};
    return w;
  endfunction

  // Monitor: samples on the falling edge what the next rising edge will do
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (pend) begin
        chk("latency", 72'(bus.valid_out), 72'd1);
        pend = 0;
      end
      if (took) begin
        if (bus.valid_in) chk("rdy_after_take", 72'(bus.ready_out), 72'd1);
        took = 0;
      end
      if (bus.valid_out && bus.busy_in && sb.size() > 0) begin
        chk("hold_data", bus.data_out, sb[0].data);
        chk("hold_rdy", 72'(bus.ready_out), 72'd0);
      end
      if (bus.valid_out && !bus.busy_in) begin
        if (sb.size() == 0) chk("spurious_win", 72'(bus.valid_out), 72'd0);
        else begin
          e = sb.pop_front();
          chk("win", bus.data_out, e.data);
          chk("last", 72'(bus.last_out), 72'(e.last));
          n_win++;
          if (bus.last_out) n_last++;
          chk("last_idx", 72'(bus.last_out), 72'((n_win % 6) == 0));
          if (first_chk) begin
            chk("first_win", bus.data_out, FIRST_WIN);
            first_chk = 0;
          end
          if (e.last && e.f == 0) chk("last_win", bus.data_out, LAST_WIN);
          took = 1;
        end
      end
      if (bus.valid_in && bus.ready_out && drv_r >= 2 && drv_c >= 2) begin
        sb.push_back('{win_at(drv_f, drv_r, drv_c), (drv_r == H - 1) && (drv_c == W - 1), drv_f});
        pend = 1;
      end
    end
  end

  initial forever begin
    @(posedge i_clk);
    #1;
    if (busy_rand) bus.busy_in = 1'($urandom_range(0, 1));
  end

  // Entered and left at posedge+1
  task automatic send_px(input int f, input int r, input int c, input int gap);
    bit acc = 0;
    int n = 0;
    bus.valid_in = 1'b0;
    repeat (gap) begin
      @(posedge i_clk);
      #1;
    end
    drv_f = f; drv_r = r; drv_c = c;
    bus.data_in  = pix(f, r, c);
    bus.valid_in = 1'b1;
    while (!acc && n < 200) begin
      @(negedge i_clk);
      acc = bus.ready_out;
      n++;
    end
    if (!acc) chk("accept_timeout", 72'(bus.ready_out), 72'd1);
    @(posedge i_clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic send_range(input int f, input int i0, input int i1, input int maxgap);
    for (int i = i0; i <= i1; i++)
      send_px(f, i / W, i % W, $urandom_range(0, maxgap));
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.busy_in  = 1'b0;
    #3;
    chk("rst_vld",  72'(bus.valid_out), 72'd0);
    chk("rst_last", 72'(bus.last_out), 72'd0);
    chk("rst_data", bus.data_out, 72'd0);
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    #1 chk("rst_rdy", 72'(bus.ready_out), 72'd1);

    // Frame 0: continuous stream, kernel never busy
    send_range(0, 0, W * H - 1, 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("nwin_f0",  72'(n_win), 72'd6);
    chk("nlast_f0", 72'(n_last), 72'd1);

    // Frame 1: hold the first window for 10 busy cycles
    bus.busy_in = 1'b1;
    send_range(1, 0, 2 * W + 2, 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      chk("busy_vld",  72'(bus.valid_out), 72'd1);
      chk("busy_rdy",  72'(bus.ready_out), 72'd0);
      chk("busy_data", bus.data_out, win_at(1, 2, 2));
    end
    @(posedge i_clk);
    #1 bus.busy_in = 1'b0;
    @(negedge i_clk);
    @(posedge i_clk);
    #1;
    chk("rdy_back", 72'(bus.ready_out), 72'd1);
    chk("vld_back", 72'(bus.valid_out), 72'd0);

    // Rest of frame 1 plus frames 2 and 3, random gaps and busy
    busy_rand = 1;
    send_range(1, 2 * W + 3, W * H - 1, 3);
    send_range(2, 0, W * H - 1, 3);
    send_range(3, 0, W * H - 1, 3);
    busy_rand = 0;
    @(posedge i_clk);
    #1 bus.busy_in = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    chk("nwin_f3",  72'(n_win), 72'd24);
    chk("nlast_f3", 72'(n_last), 72'd4);

    // Reset while a window is held
    bus.busy_in = 1'b1;
    send_range(2, 0, 2 * W + 2, 0);
    #2 i_rst = 1'b1;
    #1;
    chk("rst_hold_vld",  72'(bus.valid_out), 72'd0);
    chk("rst_hold_last", 72'(bus.last_out), 72'd0);
    chk("rst_hold_data", bus.data_out, 72'd0);
    sb.delete();
    pend = 0;
    took = 0;
    first_chk = 1;
    bus.busy_in = 1'b0;
    @(posedge i_clk);
    #1 i_rst = 1'b0;

    send_range(0, 0, W * H - 1, 0);
    repeat (3) @(posedge i_clk);
    #1;
    chk("nwin_restart",  72'(n_win), 72'd30);
    chk("nlast_restart", 72'(n_last), 72'd5);
    chk("sb_empty", 72'(sb.size()), 72'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
